// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter onto one shared memory bus, with a per-transaction timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build is fixed priority.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  m_valid,
  input  logic [7:0]  m_wstrb,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic [1:0]  m_ready,
  output logic [31:0] m_rdata,
  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [15:0] TcntMax = 16'(TIMEOUT_CYCLES - 1);

  state_e      r_state;
  logic        r_gnt_idx;
  logic        r_last_idx;
  logic [15:0] r_tcnt;

  logic w_busy;
  logic w_req;
  logic w_tcnt_max;
  logic w_done;
  logic w_tout;
  logic w_both_pick;
  logic w_pick;

  assign w_busy     = (r_state == StBusy);
  assign w_req      = w_busy & m_valid[r_gnt_idx];
  assign w_tcnt_max = (r_tcnt == TcntMax);
  assign w_done     = w_req & s_ready;
  // A slave response in the final cycle still counts as a normal completion.
  assign w_tout     = w_req & ~s_ready & w_tcnt_max;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_both_pick = ~r_last_idx;
`else
  // last_idx is tracked in both builds; fixed priority simply ignores it.
  assign w_both_pick = 1'b0 & r_last_idx;
`endif

  always_comb begin
    unique case (m_valid)
      2'b01:   w_pick = 1'b0;
      2'b10:   w_pick = 1'b1;
      default: w_pick = w_both_pick;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= StIdle;
      r_gnt_idx  <= 1'b0;
      r_last_idx <= 1'b1;
      r_tcnt     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|m_valid) begin
            r_gnt_idx <= w_pick;
            r_tcnt    <= '0;
            r_state   <= StBusy;
          end
        end
        StBusy: begin
          if (!m_valid[r_gnt_idx]) begin
            r_state <= StIdle;
          end else if (s_ready || w_tcnt_max) begin
            r_last_idx <= r_gnt_idx;
            r_state    <= StIdle;
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outputs decode from state so an asynchronous reset clears them immediately.
  always_comb begin
    m_ready     = 2'b00;
    m_rdata     = '0;
    s_valid     = 1'b0;
    s_wstrb     = '0;
    s_addr      = '0;
    s_wdata     = '0;
    grant       = 2'b00;
    timeout_err = 1'b0;
    if (w_busy) begin
      grant[r_gnt_idx]   = 1'b1;
      s_valid            = m_valid[r_gnt_idx];
      s_wstrb            = r_gnt_idx ? m_wstrb[7:4]   : m_wstrb[3:0];
      s_addr             = r_gnt_idx ? m_addr[63:32]  : m_addr[31:0];
      s_wdata            = r_gnt_idx ? m_wdata[63:32] : m_wdata[31:0];
      m_ready[r_gnt_idx] = w_done | w_tout;
      m_rdata            = w_done ? s_rdata : 32'h0;
      timeout_err        = w_tout;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned T = 4;

  logic        clk;
  logic        resetn;
  logic [1:0]  m_valid;
  logic [7:0]  m_wstrb;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [1:0]  m_ready;
  logic [31:0] m_rdata;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        timeout_err;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m_valid     (m_valid),
    .m_wstrb     (m_wstrb),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_ready     (m_ready),
    .m_rdata     (m_rdata),
    .s_valid     (s_valid),
    .s_wstrb     (s_wstrb),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic [1:0] G1 = 2'b10;
  localparam bit RoundRobin = 1'b1;
`else
  localparam logic [1:0] G1 = 2'b01;
  localparam bit RoundRobin = 1'b0;
`endif

  int n_pass;
  int n_checks;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [127:0] pack_out(input logic [1:0] mr, input logic [31:0] rd,
                                            input logic sv, input logic [3:0] ws,
                                            input logic [31:0] ad, input logic [31:0] wd,
                                            input logic [1:0] g, input logic e);
    return {22'b0, mr, rd, sv, ws, ad, wd, g, e};
  endfunction

  logic [127:0] w_act;
  assign w_act = pack_out(m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata, grant,
                          timeout_err);

  task automatic drive(input logic [1:0] mv, input logic sr, input logic [31:0] srd);
    m_valid = mv;
    s_ready = sr;
    s_rdata = srd;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m_valid = 2'b00;
    s_ready = 1'b0;
    resetn  = 1'b0;
    @(posedge clk);
    #1;
    resetn  = 1'b1;
  endtask

  // Reference model: a transaction record (owner, age) plus the last completed owner.
  bit md_busy;
  int md_owner;
  int md_last;
  int md_age;

  function automatic logic [127:0] model_out();
    logic [1:0] mr;
    logic [31:0] rd;
    logic e;
    if (!md_busy) return '0;
    mr = 2'b00;
    rd = 32'h0;
    e  = 1'b0;
    if (m_valid[md_owner]) begin
      if (s_ready) begin
        mr = 2'(1 << md_owner);
        rd = s_rdata;
      end else if (md_age == int'(T) - 1) begin
        mr = 2'(1 << md_owner);
        e  = 1'b1;
      end
    end
    return pack_out(mr, rd, m_valid[md_owner], m_wstrb[md_owner*4 +: 4],
                    m_addr[md_owner*32 +: 32], m_wdata[md_owner*32 +: 32],
                    2'(1 << md_owner), e);
  endfunction

  task automatic model_step();
    if (!md_busy) begin
      if (m_valid != 2'b00) begin
        md_busy = 1'b1;
        md_age  = 0;
        if (m_valid == 2'b01) md_owner = 0;
        else if (m_valid == 2'b10) md_owner = 1;
        else md_owner = RoundRobin ? 1 - md_last : 0;
      end
    end else if (!m_valid[md_owner]) begin
      md_busy = 1'b0;
    end else if (s_ready || md_age == int'(T) - 1) begin
      md_busy = 1'b0;
      md_last = md_owner;
    end else begin
      md_age++;
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  mv;
    logic        sr;
    logic [31:0] srd;
    logic [1:0]  g;
    logic [1:0]  mr;
    logic        sv;
    logic [31:0] rd;
    logic        e;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{1'b0, 2'b01, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'b01, 1'b0, 32'h0,        2'b01, 2'b00, 1'b1, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h0,        2'b01, 2'b00, 1'b1, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'hDEADBEEF, 2'b01, 2'b01, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 2'b11, 1'b1, 32'hCAFE0000, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 2'b11, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 2'b11, 1'b0, 32'h0,        2'b01, 2'b00, 1'b1, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 2'b11, 1'b1, 32'hA1,       2'b01, 2'b01, 1'b1, 32'hA1,       1'b0};
    vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h0,        G1,    2'b00, 1'b1, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 2'b11, 1'b1, 32'hA2,       G1,    G1,    1'b1, 32'hA2,       1'b0};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h0,        2'b01, 2'b00, 1'b1, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 2'b11, 1'b1, 32'hA3,       2'b01, 2'b01, 1'b1, 32'hA3,       1'b0};
    vecs[15] = '{1'b0, 2'b11, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
    vecs[16] = '{1'b0, 2'b11, 1'b0, 32'h0,        G1,    2'b00, 1'b1, 32'h0,        1'b0};
    vecs[17] = '{1'b0, 2'b11, 1'b1, 32'hA4,       G1,    G1,    1'b1, 32'hA4,       1'b0};
    vecs[18] = '{1'b0, 2'b00, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 32'h0,        1'b0};

    n_pass   = 0;
    n_checks = 0;
    resetn   = 1'b0;
    m_valid  = 2'b00;
    s_ready  = 1'b0;
    s_rdata  = 32'h0;
    m_addr   = {32'h2000, 32'h100};
    m_wstrb  = 8'hF0;
    m_wdata  = {32'h12345678, 32'h0};
    @(negedge clk);
    check("reset_state", w_act, '0);
    adv();

    // Single read, reset, then four contended transactions.
    for (int i = 0; i < 19; i++) begin
      resetn  = ~vecs[i].rst;
      m_valid = vecs[i].mv;
      s_ready = vecs[i].sr;
      s_rdata = vecs[i].srd;
      @(negedge clk);
      check($sformatf("vec%0d", i), {grant, m_ready, s_valid, m_rdata, timeout_err},
            {vecs[i].g, vecs[i].mr, vecs[i].sv, vecs[i].rd, vecs[i].e});
      adv();
    end
    resetn = 1'b1;

    // Timeout on a master 1 write.
    do_reset();
    m_addr  = {32'h2000, 32'h0};
    m_wstrb = 8'hF0;
    m_wdata = {32'h12345678, 32'h0};
    drive(2'b10, 1'b0, 32'h0);
    check("to_idle", w_act, '0);
    adv();
    for (int k = 1; k <= 3; k++) begin
      drive(2'b10, 1'b0, 32'h5555AAAA);
      check($sformatf("to_busy%0d", k), w_act,
            pack_out(2'b00, 32'h0, 1'b1, 4'hF, 32'h2000, 32'h12345678, 2'b10, 1'b0));
      adv();
    end
    drive(2'b10, 1'b0, 32'h5555AAAA);
    check("to_fire", w_act,
          pack_out(2'b10, 32'h0, 1'b1, 4'hF, 32'h2000, 32'h12345678, 2'b10, 1'b1));
    adv();
    drive(2'b00, 1'b0, 32'h0);
    check("to_after", w_act, '0);
    adv();

    // s_ready in the final timeout cycle wins.
    drive(2'b01, 1'b0, 32'h0);
    adv();
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, 1'b0, 32'h0);
      adv();
    end
    drive(2'b01, 1'b1, 32'h0BADF00D);
    check("simul", w_act, pack_out(2'b01, 32'h0BADF00D, 1'b1, 4'h0, 32'h0, 32'h0, 2'b01, 1'b0));
    adv();
    drive(2'b00, 1'b0, 32'h0);
    check("simul_after", w_act, '0);
    adv();

    // Abort in the second BUSY cycle leaves last_idx untouched.
    do_reset();
    drive(2'b01, 1'b0, 32'h0);
    adv();
    drive(2'b01, 1'b0, 32'h0);
    check("ab_busy1", w_act, pack_out(2'b00, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 2'b01, 1'b0));
    adv();
    drive(2'b00, 1'b1, 32'h77);
    check("ab_drop", w_act, pack_out(2'b00, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b01, 1'b0));
    adv();
    drive(2'b11, 1'b0, 32'h0);
    check("ab_idle", w_act, '0);
    adv();
    drive(2'b11, 1'b0, 32'h0);
    check("ab_regrant", w_act, pack_out(2'b00, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 2'b01, 1'b0));
    adv();
    drive(2'b11, 1'b1, 32'h1);
    adv();
    drive(2'b00, 1'b0, 32'h0);
    adv();

    // Asynchronous reset in the middle of a master 1 transaction.
    drive(2'b10, 1'b0, 32'h0);
    adv();
    m_valid = 2'b10;
    s_ready = 1'b1;
    s_rdata = 32'h0000FFFF;
    #2;
    check("rst_pre", w_act,
          pack_out(2'b10, 32'h0000FFFF, 1'b1, 4'hF, 32'h2000, 32'h12345678, 2'b10, 1'b0));
    resetn = 1'b0;
    #1;
    check("rst_async", w_act, '0);
    adv();
    resetn = 1'b1;
    drive(2'b11, 1'b0, 32'h0);
    check("rst_idle", w_act, '0);
    adv();
    drive(2'b11, 1'b0, 32'h0);
    check("rst_regrant", w_act, pack_out(2'b00, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0, 2'b01, 1'b0));
    adv();

    // Randomized traffic against the reference model.
    do_reset();
    md_busy  = 1'b0;
    md_owner = 0;
    md_last  = 1;
    md_age   = 0;
    begin
      logic [1:0] hold;
      hold = 2'b00;
      for (int c = 0; c < 1500; c++) begin
        for (int b = 0; b < 2; b++) if ($urandom_range(0, 7) == 0) hold[b] = ~hold[b];
        m_valid = hold;
        m_wstrb = 8'($urandom);
        m_addr  = {$urandom, $urandom};
        m_wdata = {$urandom, $urandom};
        s_ready = ($urandom_range(0, 3) == 0);
        s_rdata = $urandom;
        @(negedge clk);
        check($sformatf("rand%0d", c), w_act, model_out());
        model_step();
        adv();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: BUSY cycles without s_ready before forced completion; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port m_valid  input  2  request per master; bit i = master i.
REQ-005 SHALL have port m_wstrb  input  8  byte strobes; [4i+3:4i] = master i; all-zero = read.
REQ-006 SHALL have port m_addr  input  64  byte addresses; [32i+31:32i] = master i.
REQ-007 SHALL have port m_wdata  input  64  write data; [32i+31:32i] = master i.
REQ-008 SHALL have port m_ready  output  2  completion pulse per master.
REQ-009 SHALL have port m_rdata  output  32  read data, shared by both masters, valid only while m_ready bit is high.
REQ-010 SHALL have ports s_valid  output  1, s_wstrb  output  4, s_addr  output  32 and s_wdata  output  32, forming the request side of the shared memory bus.
REQ-011 SHALL have ports s_ready  input  1 and s_rdata  input  32, forming the response side of the shared memory bus.
REQ-012 SHALL have port grant  output  2  one-hot current owner, 00 when idle.
REQ-013 SHALL have port timeout_err  output  1  one-cycle pulse on forced completion.

Function
REQ-014 SHALL implement FSM with states IDLE and BUSY, plus registers gnt_idx (1 bit), last_idx (1 bit) and tcnt (16 bits).
REQ-015 In IDLE with any m_valid bit high, SHALL select a master per REQ-022/REQ-030, load gnt_idx and clear tcnt, and enter BUSY on the next edge; grant latency is 1 cycle.
REQ-016 In IDLE, s_valid, grant and m_ready SHALL be 0.
REQ-017 In BUSY, s_valid SHALL equal m_valid[gnt_idx], and s_wstrb, s_addr and s_wdata SHALL be combinational muxes of master gnt_idx's signals.
REQ-018 In BUSY with s_ready=1, m_ready[gnt_idx] SHALL be 1 in the same cycle, m_rdata SHALL equal s_rdata, last_idx SHALL become gnt_idx, and the FSM SHALL return to IDLE; there is one idle cycle between back-to-back transactions.
REQ-019 In BUSY with s_ready=0, tcnt SHALL increment by 1 per cycle; when tcnt equals TIMEOUT_CYCLES-1, m_ready[gnt_idx] SHALL be 1, m_rdata SHALL be 0, timeout_err SHALL be 1 for that cycle, last_idx SHALL be updated, and the FSM SHALL enter IDLE.
REQ-020 When s_ready and the timeout condition occur in the same cycle, s_ready SHALL win: normal completion, timeout_err=0.
REQ-021 When m_valid[gnt_idx] drops while in BUSY, the arbiter SHALL abort: s_valid=0 that cycle, no m_ready, enter IDLE next cycle, last_idx unchanged.
REQ-022 When only one master requests in IDLE, it SHALL be granted regardless of history.
REQ-023 A request from the non-granted master during BUSY SHALL NOT disturb the current transaction; it is served in the next IDLE decision.
REQ-024 m_ready SHALL never be asserted to a non-granted master; at most one m_ready bit is high per cycle.

Reset
REQ-025 On resetn=0 (asynchronous), the FSM SHALL be in IDLE, gnt_idx=0, last_idx=1, tcnt=0, and all outputs SHALL be 0.
REQ-026 Reset asserted mid-BUSY SHALL drop s_valid immediately and produce no m_ready pulse; operation resumes from IDLE after release.

Configuration
REQ-027 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-028 With the macro defined and both masters requesting in IDLE, the master != last_idx SHALL be granted.
REQ-029 Without the macro, and with both masters requesting, master 0 SHALL always be granted (fixed priority); last_idx SHALL still be maintained but unused.
REQ-030 Both builds SHALL be identical in every other behaviour.

Verification
REQ-031 Single read: m_valid=01, m_addr[31:0]=0x100, slave gives s_ready 2 cycles after s_valid with s_rdata=0xDEADBEEF -> s_valid high from cycle 1 after request, m_ready=01 with m_rdata=0xDEADBEEF, grant=01 throughout.
REQ-032 Contention, round-robin build: both masters hold m_valid=11 for 4 transactions, slave ready after 1 cycle -> grant sequence 01,10,01,10 with one idle cycle between grants; fixed-priority build -> 01,01,01,01.
REQ-033 Timeout: TIMEOUT_CYCLES=4, master 1 write of 0x12345678 to 0x2000 with wstrb=1111, s_ready held 0 -> m_ready=10 and timeout_err=1 in the 4th BUSY cycle, m_rdata=0, then IDLE.
REQ-034 Simultaneous events: s_ready asserted in the cycle tcnt=TIMEOUT_CYCLES-1 -> normal completion, timeout_err=0.
REQ-035 Abort and reset: master 0 drops m_valid in its 2nd BUSY cycle -> no m_ready, then IDLE; a separate run pulses resetn low mid-BUSY -> all outputs 0 asynchronously, and the next request is granted to master 0.
